rob_commit: RTL

In-order retirement stage sitting directly downstream of write-back. Each cycle it inspects the reorder-buffer entry at the head pointer. Once write-back has marked that entry valid, the stage retires it:
- non-stores write the architectural register file and clear the register-status tag;
- stores drain to data memory through a req/ack handshake.

The block owns the RoB head pointer and pops entries strictly in program order.

---
 rtl/rob_commit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rob_commit.sv
// In-order RoB retirement: writes back non-stores to the register file, drains stores to memory.
// Latency: a ready head retires one edge after it is sampled; stores take 1 cycle to mem_req plus the ack wait.
// Backpressure: mem_ack holds the stage in STORE_WAIT; an unready head stalls in RUN. Optional perf counters: COMMIT_PERF_CNT_EN.
module rob_commit #(
    parameter int WIDTH    = 32,
    parameter int ROB_SIZE = 128,
    parameter int TAG_W    = 7,
    parameter int REG_W    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             head_busy,
    input  logic             head_valid,
    input  logic             head_is_store,
    input  logic [REG_W-1:0] head_dest_reg,
    input  logic [WIDTH-1:0] head_value,
    input  logic [WIDTH-1:0] head_addr,
    input  logic [1:0]       head_size,
    output logic [TAG_W-1:0] head_ptr,
    output logic             rob_pop,
    output logic             rf_we,
    output logic [REG_W-1:0] rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             rat_clr,
    output logic [TAG_W-1:0] rat_tag,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    output logic [31:0]      retire_count,
    output logic [31:0]      store_stall_count
);

    typedef enum logic {RUN, STORE_WAIT} state_t;

    state_t           state;
    logic             head_ready;
    logic [1:0]       off;
    logic [3:0]       st_be;
    logic [WIDTH-1:0] st_wdata;
    logic [TAG_W-1:0] next_ptr;

    assign head_ready = head_busy & head_valid;
    assign off        = head_addr[1:0];
    assign next_ptr   = (head_ptr == TAG_W'(ROB_SIZE - 1)) ? '0 : head_ptr + TAG_W'(1);

    // Lane-align store data and byte enables from size and low address bits; size 11 behaves as word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = head_value;
        case (head_size)
            2'b00: begin
                st_be    = 4'b0001 << off;
                st_wdata = WIDTH'(head_value[7:0]) << {off, 3'b000};
            end
            2'b01: begin
                st_be    = 4'b0011 << {off[1], 1'b0};
                st_wdata = WIDTH'(head_value[15:0]) << {off[1], 4'b0000};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = head_value;
            end
        endcase
    end

    // Retirement FSM: pulses are cleared every cycle and re-asserted only on a retire edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            head_ptr  <= '0;
            rob_pop   <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            rat_clr   <= 1'b0;
            rat_tag   <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            rob_pop <= 1'b0;
            rf_we   <= 1'b0;
            rat_clr <= 1'b0;
            case (state)
                RUN: begin
                    if (head_ready && !head_is_store) begin
                        rf_we    <= (head_dest_reg != '0);
                        rf_waddr <= head_dest_reg;
                        rf_wdata <= head_value;
                        rat_clr  <= 1'b1;
                        rat_tag  <= head_ptr;
                        rob_pop  <= 1'b1;
                        head_ptr <= next_ptr;
                    end else if (head_ready && head_is_store) begin
                        state     <= STORE_WAIT;
                        mem_req   <= 1'b1;
                        mem_addr  <= {head_addr[WIDTH-1:2], 2'b00};
                        mem_wdata <= st_wdata;
                        mem_be    <= st_be;
                    end
                end
                STORE_WAIT: begin
                    // Request fields stay frozen until the ack edge.
                    if (mem_ack) begin
                        state    <= RUN;
                        mem_req  <= 1'b0;
                        rob_pop  <= 1'b1;
                        head_ptr <= next_ptr;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef COMMIT_PERF_CNT_EN
    logic pop_now;
    logic stall_now;

    assign pop_now   = ((state == RUN) && head_ready && !head_is_store) ||
                       ((state == STORE_WAIT) && mem_ack);
    assign stall_now = (state == STORE_WAIT) && !mem_ack;

    // Free-running wrapping counters, counted on the same edge the pop / stall occurs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_count      <= '0;
            store_stall_count <= '0;
        end else begin
            if (pop_now)   retire_count      <= retire_count + 32'd1;
            if (stall_now) store_stall_count <= store_stall_count + 32'd1;
        end
    end
`else
    assign retire_count      = '0;
    assign store_stall_count = '0;
`endif

endmodule
